// File: rtl/shf_pipe.sv
// shf_pipe: pipelined log-barrel shifter/rotator with valid/ready flow control.
// Stage k applies the 2^k step of the shift when its shift-amount bit is set.
// Every stage is registered. The whole pipe freezes while the consumer
// back-pressures a valid result.
module shf_pipe #(
  parameter  int WIDTH = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_oper,
  input  logic [WIDTH-1:0] in_x,
  input  logic [SW-1:0]    in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_err
);

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd5;

  // One barrel step of fixed distance s applied according to op.
  // Illegal codes pass data through untouched; the result is masked at the output.
  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] d,
                                                  input int               s);
    logic [WIDTH-1:0] fill;
    // For SRA the stage input MSB is always the original operand's sign bit,
    // because every earlier SRA step has already replicated it.
    fill = d[WIDTH-1] ? ~({WIDTH{1'b1}} >> s) : '0;
    // NOTE: assign a default before the case so every path drives the result; a
    // missing path in combinational code is what infers a latch.
    shift_step = d;
    case (op)
      OP_SRL:  shift_step = d >> s;
      OP_SRA:  shift_step = (d >> s) | fill;
      OP_ROR:  shift_step = (d >> s) | (d << (WIDTH - s));
      OP_SLL:  shift_step = d << s;
      OP_ROL:  shift_step = (d << s) | (d >> (WIDTH - s));
      default: shift_step = d;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR) ||
           (op == OP_SLL) || (op == OP_ROL);
  endfunction

  // Stage registers. Stage k holds the data after the 2^k step.
  // r_y[k] holds the shift-amount bits still to be consumed, right-aligned.
  // The last stage needs no shift-amount bits, so it has no r_y entry.
  logic             r_valid [SW];
  logic [2:0]       r_oper  [SW];
  logic [WIDTH-1:0] r_data  [SW];
  logic [SW-1:0]    r_y     [SW-1];

  // Per-stage inputs, taken from the request port or from the previous stage.
  logic             w_valid_in [SW];
  logic [2:0]       w_oper_in  [SW];
  logic [WIDTH-1:0] w_data_in  [SW];
  logic             w_sel      [SW];
  logic [WIDTH-1:0] w_data_nxt [SW];
  logic [SW-1:0]    w_y_src    [SW-1];

  logic w_stall;
  logic w_advance;
  logic w_illegal;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign w_valid_in[k] = in_valid;
      assign w_oper_in[k]  = in_oper;
      assign w_data_in[k]  = in_x;
      assign w_sel[k]      = in_y[0];
    end else begin : g_src
      assign w_valid_in[k] = r_valid[k-1];
      assign w_oper_in[k]  = r_oper[k-1];
      assign w_data_in[k]  = r_data[k-1];
      assign w_sel[k]      = r_y[k-1][0];
    end

    assign w_data_nxt[k] = w_sel[k] ? shift_step(w_oper_in[k], w_data_in[k], 1 << k)
                                    : w_data_in[k];

    if (k < SW - 1) begin : g_ysrc
      if (k == 0) begin : g_first
        assign w_y_src[k] = in_y;
      end else begin : g_later
        assign w_y_src[k] = r_y[k-1];
      end
    end
  end

  // Global flow control. A valid result the consumer refuses freezes every stage.
  assign out_valid = r_valid[SW-1];
  assign w_stall   = out_valid & ~out_ready;
  assign w_advance = ~w_stall;
  assign in_ready  = w_advance;

  // Advance all stages together. Bubbles move through as valid = 0. Payloads
  // change only when a real request moves in, so idle slots do not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage registers are few and flops with async reset, so clear
      // all of them, payload included. Reset values are then deterministic.
      for (int k = 0; k < SW; k++) begin
        r_valid[k] <= 1'b0;
        r_oper[k]  <= '0;
        r_data[k]  <= '0;
      end
      for (int k = 0; k < SW - 1; k++) begin
        r_y[k] <= '0;
      end
    end else if (w_advance) begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge, which is what makes this a pipeline.
      for (int k = 0; k < SW; k++) begin
        r_valid[k] <= w_valid_in[k];
        if (w_valid_in[k]) begin
          r_oper[k] <= w_oper_in[k];
          r_data[k] <= w_data_nxt[k];
        end
      end
      for (int k = 0; k < SW - 1; k++) begin
        if (w_valid_in[k]) begin
          r_y[k] <= w_y_src[k] >> 1;
        end
      end
    end
  end

  // Output decode from the final stage. Illegal codes force a zero result.
  // All outputs read 0 while no result is present.
  assign w_illegal = ~is_legal(r_oper[SW-1]);
  assign out_err   = out_valid & w_illegal;
  assign out_r     = (out_valid & ~w_illegal) ? r_data[SW-1] : '0;
  assign out_zero  = out_valid & (out_r == '0);

endmodule

// File: tb/tb_shf_pipe.sv
// tb_shf_pipe: directed, table-driven checks of shf_pipe at WIDTH=8.
// A WIDTH=32 instance covers the wide-operand corner cases.
module tb_shf_pipe;

  localparam int SW = 3;

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd5;

  typedef struct {
    logic [2:0] op;
    logic [7:0] x;
    logic [2:0] y;
    logic [7:0] r;
    logic       zero;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] r;
    logic       zero;
    logic       err;
    int         cyc;   // required cycle of appearance, -1 = don't care
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [2:0] in_oper;
  logic [7:0] in_x, out_r;
  logic [2:0] in_y;

  logic        v32, rdy32, ov32, ordy32, z32, e32;
  logic [2:0]  op32;
  logic [31:0] x32, r32;
  logic [4:0]  y32;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_res    = 0;
  bit   mon_en   = 1'b1;
  exp_t exp_q[$];
  vec_t vecs[19];

  shf_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_oper(in_oper), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_zero(out_zero), .out_err(out_err)
  );

  shf_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
    .in_oper(op32), .in_x(x32), .in_y(y32), .out_valid(ov32),
    .out_ready(ordy32), .out_r(r32), .out_zero(z32), .out_err(e32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request and hold it until accepted. Optionally queue the expected result.
  task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [2:0] y,
                      input logic [7:0] r, input logic z, input logic e,
                      input bit push, input bit lat);
    exp_t ex;
    int   t;
    @(negedge clk); #1;
    in_valid = 1'b1; in_oper = op; in_x = x; in_y = y;
    #1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk); #2;
      t++;
    end
    if (!in_ready) begin
      check("send_timeout_in_ready", in_ready, 1'b1);
    end else if (push) begin
      ex.r = r; ex.zero = z; ex.err = e;
      ex.cyc = lat ? cyc + SW : -1;
      exp_q.push_back(ex);
    end
  endtask

  task automatic idle();
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_all_results", exp_q.size(), 0);
  endtask

  task automatic run32(input string name, input logic [2:0] op, input logic [31:0] x,
                       input logic [4:0] y, input logic [31:0] exp);
    int n;
    @(negedge clk); #1;
    v32 = 1'b1; op32 = op; x32 = x; y32 = y;
    #1;
    check({name, "_in_ready"}, rdy32, 1'b1);
    n = cyc;
    @(negedge clk); #1;
    v32 = 1'b0;
    #1;
    while (!ov32 && cyc < n + 20) begin
      @(negedge clk); #2;
    end
    check({name, "_latency"}, cyc, n + 5);
    check({name, "_r"}, r32, exp);
    check({name, "_err"}, e32, 1'b0);
  endtask

  // Scoreboard: every result transferred to the consumer must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && mon_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("res%0d_r", n_res), out_r, e.r);
          check($sformatf("res%0d_zero", n_res), out_zero, e.zero);
          check($sformatf("res%0d_err", n_res), out_err, e.err);
          if (e.cyc >= 0) check($sformatf("res%0d_latency", n_res), cyc, e.cyc);
          n_res++;
        end
      end
    end
  end

  initial begin
    logic [7:0] held;
    logic [7:0] sll_exp;
    int         t;

    vecs[0]  = '{OP_SRL, 8'h96, 3'd3, 8'h12, 1'b0, 1'b0};
    vecs[1]  = '{OP_SRA, 8'h96, 3'd3, 8'hF2, 1'b0, 1'b0};
    vecs[2]  = '{OP_ROR, 8'h96, 3'd3, 8'hD2, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLL, 8'h96, 3'd3, 8'hB0, 1'b0, 1'b0};
    vecs[4]  = '{OP_ROL, 8'h96, 3'd3, 8'hB4, 1'b0, 1'b0};
    vecs[5]  = '{3'd4,   8'hFF, 3'd1, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{3'd6,   8'hFF, 3'd1, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{3'd7,   8'hFF, 3'd1, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{OP_SRL, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{OP_SRA, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    vecs[10] = '{OP_ROR, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    vecs[11] = '{OP_SLL, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    vecs[12] = '{OP_ROL, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0};
    vecs[13] = '{OP_SRL, 8'h01, 3'd1, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{OP_SRA, 8'h80, 3'd7, 8'hFF, 1'b0, 1'b0};
    vecs[15] = '{OP_ROR, 8'h01, 3'd1, 8'h80, 1'b0, 1'b0};
    vecs[16] = '{OP_ROL, 8'h80, 3'd1, 8'h01, 1'b0, 1'b0};
    vecs[17] = '{OP_SLL, 8'h01, 3'd7, 8'h80, 1'b0, 1'b0};
    vecs[18] = '{OP_SRA, 8'h7F, 3'd4, 8'h07, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_oper = '0; in_x = '0; in_y = '0; out_ready = 1'b1;
    v32 = 1'b0; op32 = '0; x32 = '0; y32 = '0; ordy32 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_r", out_r, 8'h00);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    #1 rst_n = 1'b1;

    // Back-to-back table vectors with the consumer always ready
    for (int i = 0; i < 19; i++) begin
      send(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].zero, vecs[i].err, 1'b1, 1'b1);
    end
    idle();
    drain();

    // Back-pressure: 6 requests, consumer stalls 4 cycles once the first result shows
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          sll_exp = 8'h01 << i;
          send(OP_SLL, 8'h01, 3'(i), sll_exp, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle();
      end
      begin
        t = 0;
        do begin
          @(negedge clk); #1;
          t++;
        end while (!out_valid && t < 20);
        check("stall_first_valid", out_valid, 1'b1);
        out_ready = 1'b0;
        held = out_r;
        #1;
        check("stall0_in_ready", in_ready, 1'b0);
        for (int c = 1; c < 4; c++) begin
          @(negedge clk); #2;
          check($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
          check($sformatf("stall%0d_out_r", c), out_r, held);
          check($sformatf("stall%0d_out_valid", c), out_valid, 1'b1);
        end
        @(negedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Short reset pulse with three requests in flight
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(OP_SRL, 8'hF0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_reset_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 1'b0);
    check("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_out_r", out_r, 8'h00);
    check("mid_reset_out_err", out_err, 1'b0);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);
    send(OP_ROL, 8'h81, 3'd2, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    drain();
    repeat (6) @(negedge clk);

    // Wide-operand corners on the WIDTH=32 instance
    run32("w32_sra", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    run32("w32_rol", OP_ROL, 32'h8000_0001, 5'd1,  32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shf_pipe.md
SHF_PIPE -- requirements
Module: shf_pipe

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning the data width in bits; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL provide derived localparam SW = log2(WIDTH), meaning the shift-amount width and the pipeline stage count.
REQ-003 Port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  meaning the reset; asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  meaning in_oper/in_x/in_y carry a request.
REQ-006 Port in_ready  output  1  meaning the block accepts a request this cycle.
REQ-007 Port in_oper  input  3  meaning the operation code.
REQ-008 Port in_x  input  WIDTH  meaning the operand to be shifted.
REQ-009 Port in_y  input  SW  meaning the shift amount, 0..WIDTH-1.
REQ-010 Port out_valid  output  1  meaning out_r/out_zero/out_err are valid.
REQ-011 Port out_ready  input  1  meaning the consumer accepts the result this cycle.
REQ-012 Port out_r  output  WIDTH  meaning the shifted result.
REQ-013 Port out_zero  output  1  meaning out_r equals all-zero.
REQ-014 Port out_err  output  1  meaning in_oper was an unsupported code.

Function
REQ-015 Operation codes SHALL be: 0 SRL (zero-fill right), 1 SRA (sign-fill right), 2 ROR, 3 SLL (zero-fill left), 5 ROL.
REQ-016 Codes 4, 6 and 7 SHALL produce out_r = 0 and out_err = 1; all legal codes SHALL produce out_err = 0.
REQ-017 A shift amount of 0 with a legal code SHALL produce out_r = in_x.
REQ-018 The shifter SHALL be a log-barrel of SW stages; stage k shifts by 2^k when in_y[k] = 1 and passes through otherwise.
REQ-019 Each stage SHALL be registered; each stage register holds data, oper, the remaining in_y bits, and a valid bit.
REQ-020 A request SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1.
REQ-021 The result SHALL appear on out_valid exactly SW cycles after acceptance when no stall occurs (3 cycles at WIDTH=8).
REQ-022 The stall condition SHALL be stall = out_valid & ~out_ready.
REQ-023 in_ready SHALL equal ~stall, a combinational function of registered state and out_ready.
REQ-024 While stall = 1, every stage register SHALL hold its contents, and out_r/out_zero/out_err SHALL remain stable.
REQ-025 While stall = 0, every stage SHALL advance by one, and empty slots (valid = 0) SHALL propagate as bubbles.
REQ-026 Sustained throughput SHALL be one result per cycle when out_ready = 1 continuously.
REQ-027 Results SHALL emerge in acceptance order, with no loss and no duplication.
REQ-028 Bubble-collapsing is not required; a bubble in the pipeline does not raise in_ready during a stall.
REQ-029 out_zero SHALL be computed from the final stage data and SHALL be 1 for an illegal code.
REQ-030 SRA SHALL replicate in_x[WIDTH-1] of the original operand across all vacated bits.
REQ-031 When in_valid = 0, the input data SHALL be ignored, and the stage-0 valid bit SHALL load 0 on an advancing edge.

Reset
REQ-032 When rst_n = 0, all valid bits SHALL clear to 0 immediately, independent of clk.
REQ-033 During reset, out_valid SHALL be 0, in_ready SHALL be 1, and out_r, out_zero and out_err SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight requests; no result from before reset SHALL appear afterwards.
REQ-035 The first edge after rst_n deasserts SHALL be able to accept a request.

Verification
REQ-036 WIDTH=8, x=0x96, y=3, opers 0/1/2/3/5 back-to-back with out_ready=1 -> out_r = 0x12/0xF2/0xD2/0xB0/0xB4 on 5 consecutive cycles, the first arriving 3 cycles after the first acceptance.
REQ-037 oper=4, 6 and 7 with x=0xFF, y=1 -> out_r = 0x00, out_err = 1, out_zero = 1.
REQ-038 y=0, x=0x5A, each legal oper -> out_r = 0x5A, out_zero = 0, out_err = 0; then SRL x=0x01, y=1 -> out_r = 0x00, out_zero = 1.
REQ-039 Stream 6 requests with out_ready held low for 4 cycles once the first result is valid -> in_ready = 0 and out_r stable during the hold; all 6 results are delivered in order afterwards.
REQ-040 Pulse rst_n low for less than one clock period with 3 requests in flight -> out_valid = 0 immediately, no stale result appears, and in_ready = 1 after reset.
REQ-041 WIDTH=32, SRA x=0x80000000, y=31 -> out_r = 0xFFFFFFFF with latency 5; ROL x=0x80000001, y=1 -> out_r = 0x00000003.
